// File: rtl/watchdog_timer.sv
// Watchdog timer: software-kicked down-counter that requests a fixed-length
// active-low reset pulse when a kick is missed or carries the wrong key.
module watchdog_timer #(
  parameter int unsigned       CNT_W        = 24,
  parameter logic [CNT_W-1:0]  DEFAULT_LOAD = CNT_W'(24'hFF_FFFF),
  parameter int unsigned       WARN_CYCLES  = 1024,
  parameter logic [31:0]       KICK_KEY     = 32'h5AA5_C33C,
  parameter int unsigned       BITE_CYCLES  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rst_wdt,
  output logic        o_irq
);

  localparam int unsigned    BW        = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;
  localparam logic [BW-1:0]  BITE_LAST = BW'(BITE_CYCLES - 1);

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_LOAD  = 2'd1;
  localparam logic [1:0] ADDR_KICK  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_BITE     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             lock_q, lock_d;
  logic             warn_ie_q, warn_ie_d;
  logic             warn_q, warn_d;
  logic             last_bite_q, last_bite_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BW-1:0]    bite_cnt_q, bite_cnt_d;
  logic             rst_wdt_q, rst_wdt_d;
  logic             irq_q, irq_d;

  logic wr_ok;
  logic wr_ctrl;
  logic wr_load;
  logic wr_kick;
  logic kick_good;

  // Register writes are locked out for the whole reset pulse.
  assign wr_ok     = i_we && (state_q != ST_BITE);
  assign wr_ctrl   = wr_ok && (i_addr == ADDR_CTRL);
  assign wr_load   = wr_ok && (i_addr == ADDR_LOAD);
  assign wr_kick   = wr_ok && (i_addr == ADDR_KICK);
  assign kick_good = wr_kick && (i_wdata == KICK_KEY);

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    lock_d      = lock_q;
    warn_ie_d   = warn_ie_q;
    warn_d      = warn_q;
    last_bite_d = last_bite_q;
    load_d      = load_q;
    count_d     = count_q;
    bite_cnt_d  = bite_cnt_q;

    if (wr_ctrl) begin
      if (!lock_q) begin
        en_d      = i_wdata[0];
        warn_ie_d = i_wdata[2];
      end
      lock_d = lock_q | i_wdata[1];
      if (i_wdata[8]) warn_d      = 1'b0;
      if (i_wdata[9]) last_bite_d = 1'b0;
    end

    if (wr_load && !lock_q) begin
      load_d = i_wdata[CNT_W-1:0];
    end

    case (state_q)
      ST_DISABLED: begin
        if (wr_ctrl && en_d) begin
          state_d = ST_RUNNING;
          count_d = load_d;
        end
      end
      ST_RUNNING: begin
        // A valid kick beats an expiring count in the same cycle.
        if (!en_d) begin
          state_d = ST_DISABLED;
        end else if (kick_good) begin
          count_d = load_d;
          warn_d  = 1'b0;
        end else if (wr_kick || (count_q == '0)) begin
          state_d    = ST_BITE;
          bite_cnt_d = '0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_BITE: begin
        if (bite_cnt_q == BITE_LAST) begin
          last_bite_d = 1'b1;
          warn_d      = 1'b0;
          if (lock_q) begin
            state_d = ST_RUNNING;
            count_d = load_q;
          end else begin
            en_d    = 1'b0;
            state_d = ST_DISABLED;
          end
        end else begin
          bite_cnt_d = bite_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    // Applied last so a simultaneous W1C of WARN loses to the set.
    if ((state_q == ST_RUNNING) && (state_d == ST_RUNNING) && !warn_q &&
        (32'(count_d) <= WARN_CYCLES)) begin
      warn_d = 1'b1;
    end

    rst_wdt_d = (state_d != ST_BITE);
    irq_d     = warn_q & warn_ie_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_DISABLED;
      en_q        <= 1'b0;
      lock_q      <= 1'b0;
      warn_ie_q   <= 1'b0;
      warn_q      <= 1'b0;
      last_bite_q <= 1'b0;
      load_q      <= DEFAULT_LOAD;
      count_q     <= DEFAULT_LOAD;
      bite_cnt_q  <= '0;
      rst_wdt_q   <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      lock_q      <= lock_d;
      warn_ie_q   <= warn_ie_d;
      warn_q      <= warn_d;
      last_bite_q <= last_bite_d;
      load_q      <= load_d;
      count_q     <= count_d;
      bite_cnt_q  <= bite_cnt_d;
      rst_wdt_q   <= rst_wdt_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_CTRL:  o_rdata = {22'd0, last_bite_q, warn_q, 5'd0, warn_ie_q, lock_q, en_q};
      ADDR_LOAD:  o_rdata = 32'(load_q);
      ADDR_KICK:  o_rdata = '0;
      ADDR_COUNT: o_rdata = 32'(count_q);
      default:    o_rdata = '0;
    endcase
  end

  assign o_rst_wdt = rst_wdt_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: per-scenario tasks with a scoreboard
// queue of expected per-cycle (o_rst_wdt, o_irq) values.
module tb_watchdog_timer;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DEF_LOAD = 16'd100;
  localparam int unsigned WARN_C = 5;
  localparam logic [31:0] KEY = 32'h5AA5_C33C;
  localparam int unsigned BITE_C = 4;

  localparam logic [1:0] A_CTRL = 2'd0, A_LOAD = 2'd1, A_KICK = 2'd2, A_COUNT = 2'd3;

  logic        i_clk;
  logic        i_rst;
  logic        i_we;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rst_wdt;
  logic        o_irq;

  typedef struct {
    logic rst;
    logic irq;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] rd;

  watchdog_timer #(
    .CNT_W(CNT_W),
    .DEFAULT_LOAD(DEF_LOAD),
    .WARN_CYCLES(WARN_C),
    .KICK_KEY(KEY),
    .BITE_CYCLES(BITE_C)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_rst_wdt(o_rst_wdt),
    .o_irq(o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive a write that lands on the next rising edge; returns 1 unit after it.
  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    i_we = 1'b1;
    i_addr = a;
    i_wdata = d;
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    i_wdata = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    i_addr = a;
    #1;
    d = o_rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Pop one scoreboard entry per edge and compare both outputs.
  task automatic drain_sb(input string tag);
    int k;
    k = 0;
    while (sb.size() > 0) begin
      step(1);
      k++;
      e = sb.pop_front();
      n_checks++;
      if (o_rst_wdt !== e.rst) begin
        n_fail++;
        $display("[TB] FAIL %s_rst edge=%0d got=%b exp=%b", tag, k, o_rst_wdt, e.rst);
      end
      n_checks++;
      if (o_irq !== e.irq) begin
        n_fail++;
        $display("[TB] FAIL %s_irq edge=%0d got=%b exp=%b", tag, k, o_irq, e.irq);
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl got=%h exp=%h", rd, 32'h0); end
    read_reg(A_LOAD, rd);
    n_checks++;
    if (rd !== 32'(DEF_LOAD)) begin n_fail++; $display("[TB] FAIL reset_load got=%h exp=%h", rd, 32'(DEF_LOAD)); end
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'(DEF_LOAD)) begin n_fail++; $display("[TB] FAIL reset_count got=%h exp=%h", rd, 32'(DEF_LOAD)); end
    n_checks++;
    if (o_rst_wdt !== 1'b1 || o_irq !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_outputs got=%b%b exp=10", o_rst_wdt, o_irq);
    end
    do_write(A_KICK, 32'h1);
    read_reg(A_KICK, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL kick_read got=%h exp=%h", rd, 32'h0); end
    for (int i = 0; i < 2 * int'(DEF_LOAD); i++) sb.push_back('{rst: 1'b1, irq: 1'b0});
    drain_sb("idle");
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'(DEF_LOAD)) begin n_fail++; $display("[TB] FAIL idle_count got=%h exp=%h", rd, 32'(DEF_LOAD)); end
  endtask

  task automatic test_auto_bite();
    $display("[TB] test_auto_bite");
    do_write(A_LOAD, 32'd10);
    do_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 16; k++) sb.push_back('{rst: !(k >= 11 && k <= 14), irq: 1'b0});
    drain_sb("auto");
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h200) begin n_fail++; $display("[TB] FAIL auto_ctrl got=%h exp=%h", rd, 32'h200); end
    step(5);
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL auto_frozen got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_warn_kick();
    $display("[TB] test_warn_kick");
    do_write(A_LOAD, 32'd20);
    do_write(A_CTRL, 32'h204);
    do_write(A_CTRL, 32'h005);
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 14; k++) sb.push_back('{rst: 1'b1, irq: 1'b0});
      drain_sb("kicked");
      do_write(A_KICK, KEY);
    end
    for (int k = 1; k <= 26; k++) begin
      step(1);
      n_checks++;
      if (o_rst_wdt !== !(k >= 21 && k <= 24)) begin
        n_fail++; $display("[TB] FAIL warn_rst edge=%0d got=%b exp=%b", k, o_rst_wdt, !(k >= 21 && k <= 24));
      end
      n_checks++;
      if (o_irq !== (k >= 16 && k <= 25)) begin
        n_fail++; $display("[TB] FAIL warn_irq edge=%0d got=%b exp=%b", k, o_irq, (k >= 16 && k <= 25));
      end
      if (k == 15) begin
        read_reg(A_CTRL, rd);
        n_checks++;
        if (rd[8] !== 1'b1) begin n_fail++; $display("[TB] FAIL warn_bit got=%b exp=1", rd[8]); end
      end
    end
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h204) begin n_fail++; $display("[TB] FAIL warn_end_ctrl got=%h exp=%h", rd, 32'h204); end
  endtask

  task automatic test_bad_kick();
    $display("[TB] test_bad_kick");
    do_write(A_CTRL, 32'h300);
    do_write(A_LOAD, 32'd50);
    do_write(A_CTRL, 32'h1);
    step(3);
    do_write(A_KICK, 32'h0000_0001);
    n_checks++;
    if (o_rst_wdt !== 1'b0) begin n_fail++; $display("[TB] FAIL badkick_fall got=%b exp=0", o_rst_wdt); end
    do_write(A_LOAD, 32'd7);
    n_checks++;
    if (o_rst_wdt !== 1'b0) begin n_fail++; $display("[TB] FAIL badkick_hold got=%b exp=0", o_rst_wdt); end
    sb.push_back('{rst: 1'b0, irq: 1'b0});
    sb.push_back('{rst: 1'b0, irq: 1'b0});
    sb.push_back('{rst: 1'b1, irq: 1'b0});
    drain_sb("badkick");
    read_reg(A_LOAD, rd);
    n_checks++;
    if (rd !== 32'd50) begin n_fail++; $display("[TB] FAIL bite_wr_ignored got=%h exp=%h", rd, 32'd50); end
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h200) begin n_fail++; $display("[TB] FAIL badkick_ctrl got=%h exp=%h", rd, 32'h200); end
  endtask

  task automatic test_kick_at_zero();
    $display("[TB] test_kick_at_zero");
    do_write(A_CTRL, 32'h200);
    do_write(A_LOAD, 32'd3);
    do_write(A_CTRL, 32'h1);
    step(3);
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_count got=%h exp=%h", rd, 32'h0); end
    do_write(A_KICK, KEY);
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd3 || o_rst_wdt !== 1'b1) begin
      n_fail++; $display("[TB] FAIL zero_kick got=%h/%b exp=%h/1", rd, o_rst_wdt, 32'd3);
    end
    for (int k = 1; k <= 8; k++) sb.push_back('{rst: !(k >= 4 && k <= 7), irq: 1'b0});
    drain_sb("zero");
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h200) begin n_fail++; $display("[TB] FAIL zero_ctrl got=%h exp=%h", rd, 32'h200); end
  endtask

  task automatic test_lock();
    $display("[TB] test_lock");
    do_write(A_CTRL, 32'h300);
    do_write(A_LOAD, 32'd8);
    do_write(A_CTRL, 32'h3);
    do_write(A_CTRL, 32'h0);
    do_write(A_LOAD, 32'd30);
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("[TB] FAIL lock_ctrl got=%h exp=%h", rd, 32'h3); end
    read_reg(A_LOAD, rd);
    n_checks++;
    if (rd !== 32'd8) begin n_fail++; $display("[TB] FAIL lock_load got=%h exp=%h", rd, 32'd8); end
    step(10);
    n_checks++;
    if (o_rst_wdt !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_bite got=%b exp=0", o_rst_wdt); end
    step(1);
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd8 || o_rst_wdt !== 1'b1) begin
      n_fail++; $display("[TB] FAIL lock_rearm got=%h/%b exp=%h/1", rd, o_rst_wdt, 32'd8);
    end
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h203) begin n_fail++; $display("[TB] FAIL lock_ctrl2 got=%h exp=%h", rd, 32'h203); end
    step(1);
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'd7) begin n_fail++; $display("[TB] FAIL lock_running got=%h exp=%h", rd, 32'd7); end
    do_write(A_CTRL, 32'h200);
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h3) begin n_fail++; $display("[TB] FAIL lock_w1c got=%h exp=%h", rd, 32'h3); end
  endtask

  task automatic test_async_reset();
    int waited;
    $display("[TB] test_async_reset");
    waited = 0;
    while (o_rst_wdt !== 1'b0 && waited < 40) begin
      step(1);
      waited++;
    end
    n_checks++;
    if (o_rst_wdt !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_wait_bite got=%b exp=0 after %0d cycles", o_rst_wdt, waited);
    end
    step(1);
    #2;
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_rst_wdt !== 1'b1) begin n_fail++; $display("[TB] FAIL async_force got=%b exp=1", o_rst_wdt); end
    #1;
    i_rst = 1'b1;
    step(1);
    read_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL async_ctrl got=%h exp=%h", rd, 32'h0); end
    read_reg(A_COUNT, rd);
    n_checks++;
    if (rd !== 32'(DEF_LOAD)) begin n_fail++; $display("[TB] FAIL async_count got=%h exp=%h", rd, 32'(DEF_LOAD)); end
    read_reg(A_LOAD, rd);
    n_checks++;
    if (rd !== 32'(DEF_LOAD)) begin n_fail++; $display("[TB] FAIL async_load got=%h exp=%h", rd, 32'(DEF_LOAD)); end
  endtask

  initial begin
    i_rst = 1'b0;
    i_we = 1'b0;
    i_addr = '0;
    i_wdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    test_reset();
    test_auto_bite();
    test_warn_kick();
    test_bad_kick();
    test_kick_at_zero();
    test_lock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
